baud_cfg_ctrl: RTL and testbench

Configuration sequencer for the UART receive baud generator (`BaudGenR`). It accepts baud-rate change requests over a req/ack handshake and waits until the receiver is idle before touching the generator. It then holds the generator in reset, applies the new 2-bit rate code and confirms that the generator is ticking before re-enabling the receiver. It sits between the host/register interface and the `BaudGenR` + UART RX pair, all in the 50 MHz system clock domain.

---
 rtl/baud_cfg_ctrl.sv | 156 +++++++++++++++
 tb/tb_baud_cfg_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/baud_cfg_ctrl.sv
// Rate-change sequencer for the RX baud generator: waits for an idle receiver, holds the
// generator in reset while the new rate code is applied, then confirms it ticks again.
module baud_cfg_ctrl #(
  parameter int          HOLD_CYCLES    = 4,
  parameter int          VERIFY_TIMEOUT = 50000,
  parameter logic [1:0]  DEFAULT_RATE   = 2'b00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cfg_req,
  input  logic [1:0] cfg_rate,
  output logic       cfg_busy,
  output logic       cfg_ack,
  output logic       cfg_err,
  input  logic       rx_busy,
  output logic       rx_enable,
  input  logic       baud_clk,
  output logic [1:0] baud_rate,
  output logic       gen_reset_n
);

  localparam int CNT_MAX = (HOLD_CYCLES > VERIFY_TIMEOUT) ? HOLD_CYCLES : VERIFY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] VERIFY_LAST = CNT_W'(VERIFY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

  typedef enum logic [2:0] {
    BOOT      = 3'd0,
    IDLE      = 3'd1,
    WAIT_IDLE = 3'd2,
    HOLD      = 3'd3,
    VERIFY    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       pending, pending_nxt, rate_nxt;
  logic             baud_clk_q, baud_edge;
  logic             busy_nxt, ack_nxt, err_nxt, rx_en_nxt, gen_nxt;

  assign baud_edge = baud_clk & ~baud_clk_q;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
    pending_nxt = pending;
    rate_nxt    = baud_rate;
    busy_nxt    = cfg_busy;
    ack_nxt     = 1'b0;
    err_nxt     = cfg_err;
    rx_en_nxt   = rx_enable;
    gen_nxt     = gen_reset_n;
    case (state)
      BOOT: begin
        if (cnt >= HOLD_LAST) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          rx_en_nxt = 1'b1;
          gen_nxt   = 1'b1;
        end else begin
          state_nxt = BOOT;
        end
      end
      IDLE: begin
        if (cfg_req) begin
          pending_nxt = cfg_rate;
          err_nxt     = 1'b0;
          if (cfg_rate == baud_rate) begin
            ack_nxt = 1'b1;
          end else begin
            state_nxt = WAIT_IDLE;
            busy_nxt  = 1'b1;
            rx_en_nxt = 1'b0;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_IDLE: begin
        // The rate code only moves on the edge that also pulls the generator into reset.
        if (!rx_busy) begin
          state_nxt = HOLD;
          rate_nxt  = pending;
          gen_nxt   = 1'b0;
          cnt_nxt   = CNT_ZERO;
        end else begin
          state_nxt = WAIT_IDLE;
        end
      end
      HOLD: begin
        if (cnt >= HOLD_LAST) begin
          state_nxt = VERIFY;
          gen_nxt   = 1'b1;
          cnt_nxt   = CNT_ZERO;
        end else begin
          state_nxt = HOLD;
        end
      end
      VERIFY: begin
        if (baud_edge) begin
          state_nxt = IDLE;
          ack_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          rx_en_nxt = 1'b1;
        end else if (cnt >= VERIFY_LAST) begin
          // Timed out: finish anyway with the new rate kept, flagging the error.
          state_nxt = IDLE;
          ack_nxt   = 1'b1;
          err_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          rx_en_nxt = 1'b1;
        end else begin
          state_nxt = VERIFY;
        end
      end
      default: begin
        state_nxt = BOOT;
        cnt_nxt   = CNT_ZERO;
        busy_nxt  = 1'b1;
        rx_en_nxt = 1'b0;
        gen_nxt   = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    baud_clk_q <= baud_clk;
    if (reset) begin
      state       <= BOOT;
      cnt         <= CNT_ZERO;
      pending     <= DEFAULT_RATE;
      baud_rate   <= DEFAULT_RATE;
      gen_reset_n <= 1'b0;
      rx_enable   <= 1'b0;
      cfg_busy    <= 1'b1;
      cfg_ack     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pending     <= pending_nxt;
      baud_rate   <= rate_nxt;
      gen_reset_n <= gen_nxt;
      rx_enable   <= rx_en_nxt;
      cfg_busy    <= busy_nxt;
      cfg_ack     <= ack_nxt;
      cfg_err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Directed bench for baud_cfg_ctrl: boot, full and fast rate changes, busy receiver,
// verify timeout, ignored requests and reset in the middle of a change.
module tb_baud_cfg_ctrl;

  logic       clock = 1'b0;
  logic       reset, cfg_req, rx_busy, baud_clk;
  logic [1:0] cfg_rate;
  logic       cfg_busy, cfg_ack, cfg_err, rx_enable, gen_reset_n;
  logic [1:0] baud_rate;
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clock = ~clock;

  baud_cfg_ctrl #(
    .HOLD_CYCLES    (4),
    .VERIFY_TIMEOUT (100),
    .DEFAULT_RATE   (2'b00)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_req     (cfg_req),
    .cfg_rate    (cfg_rate),
    .cfg_busy    (cfg_busy),
    .cfg_ack     (cfg_ack),
    .cfg_err     (cfg_err),
    .rx_busy     (rx_busy),
    .rx_enable   (rx_enable),
    .baud_clk    (baud_clk),
    .baud_rate   (baud_rate),
    .gen_reset_n (gen_reset_n)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {1'b0, obs}, {1'b0, exp});
  endtask

  task automatic cyc;
    @(negedge clock);
  endtask

  // Called on the negedge where reset was just dropped.
  task automatic boot_seq(input string tag);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk1({tag, "_gen_low"}, gen_reset_n, 1'b0);
      chk1({tag, "_no_ack"}, cfg_ack, 1'b0);
    end
    cyc();
    chk1({tag, "_gen_high"}, gen_reset_n, 1'b1);
    chk1({tag, "_rx_en"}, rx_enable, 1'b1);
    chk1({tag, "_busy"}, cfg_busy, 1'b0);
    chk1({tag, "_ack"}, cfg_ack, 1'b0);
    chk({tag, "_rate"}, baud_rate, 2'b00);
  endtask

  initial begin
    reset = 1'b1; cfg_req = 1'b0; cfg_rate = 2'b00; rx_busy = 1'b0; baud_clk = 1'b0;
    repeat (5) cyc();
    chk1("rst_gen", gen_reset_n, 1'b0);
    chk1("rst_rx_en", rx_enable, 1'b0);
    chk1("rst_busy", cfg_busy, 1'b1);
    chk1("rst_ack", cfg_ack, 1'b0);
    chk1("rst_err", cfg_err, 1'b0);
    chk("rst_rate", baud_rate, 2'b00);
    reset = 1'b0;
    boot_seq("boot1");

    // Full change to rate 10, generator ticks 20 cycles after release.
    cfg_req = 1'b1; cfg_rate = 2'b10;
    cyc();
    cfg_req = 1'b0;
    chk1("full_busy", cfg_busy, 1'b1);
    chk1("full_rx_off", rx_enable, 1'b0);
    chk("full_rate_old", baud_rate, 2'b00);
    cyc();
    chk("full_rate_new", baud_rate, 2'b10);
    chk1("full_hold0", gen_reset_n, 1'b0);
    repeat (3) begin
      cyc();
      chk1("full_hold", gen_reset_n, 1'b0);
    end
    cyc();
    chk1("full_release", gen_reset_n, 1'b1);
    chk1("full_verify_busy", cfg_busy, 1'b1);
    repeat (19) cyc();
    chk1("full_pre_ack", cfg_ack, 1'b0);
    chk1("full_pre_busy", cfg_busy, 1'b1);
    baud_clk = 1'b1;
    cyc();
    baud_clk = 1'b0;
    chk1("full_ack", cfg_ack, 1'b1);
    chk1("full_ack_busy", cfg_busy, 1'b0);
    chk1("full_ack_rx_en", rx_enable, 1'b1);
    chk1("full_err", cfg_err, 1'b0);
    cyc();
    chk1("full_single_ack", cfg_ack, 1'b0);

    // Fast path: same rate again.
    cfg_req = 1'b1; cfg_rate = 2'b10;
    cyc();
    cfg_req = 1'b0;
    chk1("fast_ack", cfg_ack, 1'b1);
    chk1("fast_busy", cfg_busy, 1'b0);
    chk1("fast_gen", gen_reset_n, 1'b1);
    cyc();
    chk1("fast_ack_end", cfg_ack, 1'b0);
    chk1("fast_busy_end", cfg_busy, 1'b0);

    // Receiver busy for 200 cycles while rate 11 is requested.
    cfg_req = 1'b1; cfg_rate = 2'b11; rx_busy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      cfg_req = 1'b0;
      chk1("wait_idle_hold",
           (rx_enable === 1'b0) && (baud_rate === 2'b10) && (gen_reset_n === 1'b1), 1'b1);
    end
    rx_busy = 1'b0;
    cyc();
    chk("busy_hold_rate", baud_rate, 2'b11);
    chk1("busy_hold_gen", gen_reset_n, 1'b0);

    // Request during HOLD is ignored; generator never ticks -> timeout.
    cfg_req = 1'b1; cfg_rate = 2'b01;
    cyc();
    cfg_req = 1'b0;
    chk1("hold_req_no_ack", cfg_ack, 1'b0);
    chk1("hold_req_gen", gen_reset_n, 1'b0);
    chk("hold_req_rate", baud_rate, 2'b11);
    repeat (2) cyc();
    chk1("hold_last", gen_reset_n, 1'b0);
    cyc();
    chk1("to_release", gen_reset_n, 1'b1);
    repeat (99) cyc();
    chk1("to_pre_ack", cfg_ack, 1'b0);
    chk1("to_pre_busy", cfg_busy, 1'b1);
    cyc();
    chk1("to_ack", cfg_ack, 1'b1);
    chk1("to_err", cfg_err, 1'b1);
    chk("to_rate_kept", baud_rate, 2'b11);
    chk1("to_rx_en", rx_enable, 1'b1);
    cyc();
    chk1("to_ack_end", cfg_ack, 1'b0);
    chk1("to_err_sticky", cfg_err, 1'b1);
    chk1("to_no_queue", cfg_busy, 1'b0);
    cfg_req = 1'b1; cfg_rate = 2'b11;
    cyc();
    cfg_req = 1'b0;
    chk1("err_clr_ack", cfg_ack, 1'b1);
    chk1("err_clr", cfg_err, 1'b0);

    // Reset in the middle of VERIFY, coinciding with a generator edge.
    cfg_req = 1'b1; cfg_rate = 2'b01;
    cyc();
    cfg_req = 1'b0;
    cyc();
    chk("mid_rate", baud_rate, 2'b01);
    repeat (4) cyc();
    chk1("mid_verify", gen_reset_n, 1'b1);
    cyc();
    baud_clk = 1'b1; reset = 1'b1;
    cyc();
    baud_clk = 1'b0;
    chk("mid_rst_rate", baud_rate, 2'b00);
    chk1("mid_rst_ack", cfg_ack, 1'b0);
    chk1("mid_rst_gen", gen_reset_n, 1'b0);
    chk1("mid_rst_busy", cfg_busy, 1'b1);
    chk1("mid_rst_rx_en", rx_enable, 1'b0);
    cyc();
    chk1("mid_rst_ack2", cfg_ack, 1'b0);
    reset = 1'b0;
    boot_seq("boot2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
